// File: rtl/nibble_serial_subtractor.sv
// Sequential WIDTH-bit subtractor: d = a - b - bin, one CHUNK-bit slice per clock,
// LSB slice first, with the borrow carried between slices in a register.
module nibble_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             brw_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic             accept;
  int               slice_lo;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   sum_d;
  logic [WIDTH-1:0] d_d;
  logic             brw_d;
  logic             ovf_d;
  logic             zero_d;

  // Operands are only taken while in_ready is visible to the producer.
  assign accept = (state_q == IDLE) && in_ready_q && in_valid;

  // One slice of a + ~b + ~brw: the inverted carry-out becomes the next borrow.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    slice_lo = int'(cnt_q) * CHUNK;
    a_slice  = a_q[slice_lo +: CHUNK];
    b_slice  = b_q[slice_lo +: CHUNK];
    sum_d    = {1'b0, a_slice} + {1'b0, ~b_slice} + {{CHUNK{1'b0}}, ~brw_q};
    d_d      = d_q;
    d_d[slice_lo +: CHUNK] = sum_d[CHUNK-1:0];
    brw_d    = ~sum_d[CHUNK];
    ovf_d    = (a_q[MSB] ^ b_q[MSB]) & (d_d[MSB] ^ a_q[MSB]);
    zero_d   = (d_d == '0);
  end

  // NOTE: operand registers carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      brw_q       <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (accept) begin
            brw_q      <= bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          d_q   <= d_d;
          brw_q <= brw_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            bout_q      <= brw_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= d_d[MSB];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: the driver queues expected results,
// a monitor pops and compares them whenever a result is handed over.
module tb_nibble_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       bin_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       bout;
  logic       ovf;
  logic       zero;
  logic       neg;

  int n_total;
  int n_bad;

  // Expected word layout: {d[7:0], bout, ovf, zero, neg}.
  logic [11:0] exp_q[$];

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        bin;
    logic [11:0] exp;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC] = '{
    {8'h05, 8'h03, 1'b0, 12'h020},
    {8'h10, 8'h01, 1'b0, 12'h0F0},
    {8'h00, 8'h01, 1'b0, 12'hFF9},
    {8'h80, 8'h01, 1'b0, 12'h7F4},
    {8'h55, 8'h54, 1'b1, 12'h002},
    {8'h55, 8'h55, 1'b1, 12'hFF9},
    {8'h7F, 8'hFF, 1'b0, 12'h80D},
    {8'h00, 8'h00, 1'b1, 12'hFF9},
    {8'hF0, 8'h0F, 1'b0, 12'hE11}
  };

  nibble_serial_subtractor #(.WIDTH(8), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .bin       (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] result_word();
    return {d, bout, ovf, zero, neg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on the edge following a cycle with valid and ready both high.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(result_word()), 32'hFFFF_FFFF);
        end else begin
          check("result", 32'(result_word()), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Present one operation at a negedge and return just after its accept edge.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                       input logic [11:0] exp, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    a_in     = av;
    b_in     = bv;
    bin_in   = bv_in;
    in_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in     = ~av;
    b_in     = bv ^ 8'hA5;
    bin_in   = ~bv_in;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    bin_in    = 1'b0;

    #12;
    check("reset_outputs", 32'(result_word()), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // Directed vectors with a consumer that is always ready.
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp, 1'b1);
      wait_valid(lat);
      check("latency", 32'(lat), 32'd2);
      @(posedge clk);
      #1;
      check("one_cycle_valid", 32'(out_valid), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);
    end

    // Backpressure: result must hold while inputs churn.
    @(negedge clk);
    out_ready = 1'b0;
    issue(8'h3C, 8'hC3, 1'b0, 12'h798, 1'b1);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_in     = 8'(i * 37);
      b_in     = 8'(i * 91 + 3);
      in_valid = i[0];
      @(posedge clk);
      #1;
      check("bp_hold", 32'(result_word()), 32'h798);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Abort in the middle of a calculation.
    issue(8'h12, 8'h34, 1'b0, 12'h000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'(result_word()), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_release_in_ready", 32'(in_ready), 32'd1);
    issue(8'hFF, 8'hFF, 1'b0, 12'h002, 1'b1);
    wait_valid(lat);
    check("post_abort_latency", 32'(lat), 32'd2);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
